// File: rtl/tsi_host_pkg.sv
// Shared types and constants for the host-side serial TileLink bridge.
`default_nettype none

package tsi_host_pkg;

  localparam int TSI_WORD_W = 32;

  localparam logic [TSI_WORD_W-1:0] TSI_CMD_READ  = 32'd0;
  localparam logic [TSI_WORD_W-1:0] TSI_CMD_WRITE = 32'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR_LO = 3'd2,
    S_ADDR_HI = 3'd3,
    S_LEN_LO  = 3'd4,
    S_LEN_HI  = 3'd5,
    S_WDATA   = 3'd6,
    S_RDATA   = 3'd7
  } tsi_state_e;

endpackage

`default_nettype wire

// File: rtl/tsi_host_bridge_if.sv
// Host request, write/read data and serial link signals of the TSI host bridge.
`default_nettype none

interface tsi_host_bridge_if
  import tsi_host_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LEN_W  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [LEN_W-1:0]      req_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [TSI_WORD_W-1:0] wdata_bits;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [TSI_WORD_W-1:0] rdata_bits;
  logic                  tl_out_valid;
  logic                  tl_out_ready;
  logic [TSI_WORD_W-1:0] tl_out_bits;
  logic                  tl_in_valid;
  logic                  tl_in_ready;
  logic [TSI_WORD_W-1:0] tl_in_bits;
  logic                  busy;
  logic                  err;

  modport slave (
    input  req_valid, req_write, req_addr, req_len,
    input  wdata_valid, wdata_bits, rdata_ready,
    input  tl_out_ready, tl_in_valid, tl_in_bits,
    output req_ready, wdata_ready, rdata_valid, rdata_bits,
    output tl_out_valid, tl_out_bits, tl_in_ready, busy, err
  );

  modport master (
    output req_valid, req_write, req_addr, req_len,
    output wdata_valid, wdata_bits, rdata_ready,
    output tl_out_ready, tl_in_valid, tl_in_bits,
    input  req_ready, wdata_ready, rdata_valid, rdata_bits,
    input  tl_out_valid, tl_out_bits, tl_in_ready, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/tsi_resp_fifo.sv
// Synchronous read-data FIFO with registered full/empty and an extra pointer bit for wrap detection.
`default_nettype none

module tsi_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    empty_d = (wr_d == rd_d);
    full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;
endmodule

`default_nettype wire

// File: rtl/tsi_host_bridge.sv
// Host-side serial TileLink master: frames one request at a time onto the link and buffers read data.
// Optional watchdog enabled by defining TSI_HOST_TIMEOUT_EN.
`default_nettype none

module tsi_host_bridge
  import tsi_host_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int LEN_W       = 16,
  parameter int RESP_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clock,
  input  logic              reset_n,
  tsi_host_bridge_if.slave  bus
);
  tsi_state_e            state_q;
  logic                  write_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      beat_q;
  logic [TSI_WORD_W-1:0] hdr_q;
  logic                  hdr_vld_q;

  logic [63:0]           w_addr64;
  logic                  w_in_wdata, w_wbeat, w_push, w_last;
  logic                  w_fifo_full, w_fifo_empty, w_tl_out_valid;
  logic                  w_tmo_hit;

  assign w_addr64   = 64'(addr_q);
  assign w_in_wdata = (state_q == S_WDATA);
  assign w_wbeat    = w_in_wdata && bus.wdata_valid && bus.tl_out_ready;
  assign w_push     = (state_q == S_RDATA) && bus.tl_in_valid && !w_fifo_full;
  assign w_last     = (beat_q == len_q);

  // Header words come from a register; write data passes straight through.
  assign w_tl_out_valid  = w_in_wdata ? bus.wdata_valid : hdr_vld_q;
  assign bus.tl_out_valid = w_tl_out_valid;
  assign bus.tl_out_bits  = w_in_wdata ? bus.wdata_bits : hdr_q;
  assign bus.wdata_ready  = w_in_wdata && bus.tl_out_ready;
  assign bus.tl_in_ready  = (state_q == S_RDATA) && !w_fifo_full;
  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.rdata_valid  = !w_fifo_empty;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (bus.req_valid) begin
          write_q   <= bus.req_write;
          addr_q    <= bus.req_addr;
          len_q     <= bus.req_len;
          beat_q    <= '0;
          hdr_q     <= bus.req_write ? TSI_CMD_WRITE : TSI_CMD_READ;
          hdr_vld_q <= 1'b1;
          state_q   <= S_CMD;
        end
        S_CMD: if (bus.tl_out_ready) begin
          hdr_q   <= w_addr64[31:0];
          state_q <= S_ADDR_LO;
        end
        S_ADDR_LO: if (bus.tl_out_ready) begin
          hdr_q   <= w_addr64[63:32];
          state_q <= S_ADDR_HI;
        end
        S_ADDR_HI: if (bus.tl_out_ready) begin
          hdr_q   <= TSI_WORD_W'(len_q);
          state_q <= S_LEN_LO;
        end
        S_LEN_LO: if (bus.tl_out_ready) begin
          hdr_q   <= '0;
          state_q <= S_LEN_HI;
        end
        S_LEN_HI: if (bus.tl_out_ready) begin
          hdr_vld_q <= 1'b0;
          state_q   <= write_q ? S_WDATA : S_RDATA;
        end
        S_WDATA: if (w_wbeat) begin
          if (w_last) state_q <= S_IDLE;
          else        beat_q  <= beat_q + LEN_W'(1);
        end
        S_RDATA: if (w_push) begin
          if (w_last) state_q <= S_IDLE;
          else        beat_q  <= beat_q + LEN_W'(1);
        end
        default: state_q <= S_IDLE;
      endcase
      if (w_tmo_hit) begin
        state_q   <= S_IDLE;
        hdr_vld_q <= 1'b0;
      end
    end
  end

`ifdef TSI_HOST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_q;
  logic             err_q;
  logic             w_tmo_cnt;

  // Counts starved read cycles and stalled link words alike.
  assign w_tmo_cnt = ((state_q == S_RDATA) && !w_push) || (w_tl_out_valid && !bus.tl_out_ready);
  assign w_tmo_hit = w_tmo_cnt && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= (w_tmo_cnt && !w_tmo_hit) ? tmo_q + TMO_W'(1) : '0;
      if (w_tmo_hit) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYC > 0);
  assign w_tmo_hit  = 1'b0;
  assign bus.err    = 1'b0;
`endif

  tsi_resp_fifo #(
    .WIDTH (TSI_WORD_W),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .push_i  (w_push),
    .data_i  (bus.tl_in_bits),
    .pop_i   (bus.rdata_ready),
    .data_o  (bus.rdata_bits),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );
endmodule

`default_nettype wire
